// File: rtl/fp_op_sched.sv
// Two-requester scheduler in front of a shared FP multiply datapath.
// IEEE-754 special operands are resolved locally; normal operands go to the datapath.
module fp_op_sched #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        dp_start,
    output logic [1:0]  dp_op,
    output logic [31:0] dp_a,
    output logic [31:0] dp_b,
    input  logic        dp_done,
    input  logic [31:0] dp_res,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_special,
    output logic        rsp_err
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic        id_q, id_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] data_q, data_d;
    logic        spec_q, spec_d;
    logic        err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        gnt, acc;
    logic [1:0]  sel_op;
    logic [31:0] sel_a, sel_b;
    logic        a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    logic        r_nan, r_inf, r_zero, rsv, is_spec, sgn;
    logic [31:0] spec_data;
    logic [CNT_W-1:0] cnt_inc;

    // Both valid: serve the requester that was not granted last.
    always_comb begin
        gnt = 1'b0;
        if (req0_valid && req1_valid) gnt = ~last_q;
        else if (req1_valid)          gnt = 1'b1;
    end

    assign acc    = (state_q == IDLE) && (req0_valid || req1_valid) && !rst;
    assign req0_ready = acc && !gnt;
    assign req1_ready = acc && gnt;
    assign sel_op = gnt ? req1_op : req0_op;
    assign sel_a  = gnt ? req1_a  : req0_a;
    assign sel_b  = gnt ? req1_b  : req0_b;

    assign a_nan  = (&sel_a[30:23]) && (|sel_a[22:0]);
    assign a_inf  = (&sel_a[30:23]) && !(|sel_a[22:0]);
    assign a_zero = !(|sel_a[30:23]);
    assign b_nan  = (&sel_b[30:23]) && (|sel_b[22:0]);
    assign b_inf  = (&sel_b[30:23]) && !(|sel_b[22:0]);
    assign b_zero = !(|sel_b[30:23]);

    assign rsv    = (sel_op == 2'b11);
    assign r_nan  = a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero);
    assign r_inf  = a_inf || b_inf;
    assign r_zero = a_zero || b_zero;
    assign is_spec = rsv || r_nan || r_inf || r_zero;

    always_comb begin
        sgn = 1'b0;
        unique case (sel_op)
            2'b00:   sgn = sel_a[31] ^ sel_b[31];
            2'b01:   sgn = ~(sel_a[31] ^ sel_b[31]);
            default: sgn = 1'b0;
        endcase
    end

    always_comb begin
        spec_data = {sgn, 31'b0};
        if (rsv || r_nan) spec_data = QNAN;
        else if (r_inf)   spec_data = {sgn, 31'h7F80_0000};
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        spec_d  = spec_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    last_d = gnt;
                    id_d   = gnt;
                    op_d   = sel_op;
                    a_d    = sel_a;
                    b_d    = sel_b;
                    if (is_spec) begin
                        data_d  = spec_data;
                        spec_d  = 1'b1;
                        err_d   = rsv;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_inc;
                if (dp_done) begin
                    data_d  = dp_res;
                    spec_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    data_d  = QNAN;
                    spec_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            op_q    <= 2'b00;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            spec_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            spec_q  <= spec_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dp_start    = (state_q == ISSUE);
    assign dp_op       = op_q;
    assign dp_a        = a_q;
    assign dp_b        = b_q;
    assign rsp_valid   = (state_q == RESP);
    assign rsp_id      = id_q;
    assign rsp_data    = data_q;
    assign rsp_special = spec_q;
    assign rsp_err     = err_q;

endmodule

// File: tb/tb_fp_op_sched.sv
// Scoreboard bench for fp_op_sched with a behavioural datapath responder.
module tb_fp_op_sched;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        dp_start, dp_done;
    logic [1:0]  dp_op;
    logic [31:0] dp_a, dp_b, dp_res;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_special, rsp_err;
    logic [31:0] rsp_data;

    fp_op_sched #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .dp_start(dp_start), .dp_op(dp_op), .dp_a(dp_a), .dp_b(dp_b),
        .dp_done(dp_done), .dp_res(dp_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_special(rsp_special), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        sp;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int accepts = 0;
    int dp_starts = 0;
    int dp_lat = 3;
    bit dp_en = 1'b1;
    int stray_cnt = 0;
    logic prev_valid = 1'b0;
    logic        h_id, h_sp, h_err;
    logic [31:0] h_data;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] dpf(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        if (op == 2'b00 && a == 32'h4000_0000 && b == 32'hC040_0000)
            return 32'hC0C0_0000;
        return a ^ {b[15:0], b[31:16]} ^ {30'd0, op};
    endfunction

    task automatic push(input logic id, input logic [31:0] d,
                        input logic sp, input logic err, input int lat);
        exp_t e;
        e.id = id; e.data = d; e.sp = sp; e.err = err; e.lat = lat;
        sbq.push_back(e);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: accept timing, response latency, stall stability, scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                acc_cyc = cyc;
                accepts++;
            end
            if (dp_start) dp_starts++;
            if (rsp_valid && !prev_valid) begin
                if (sbq.size() == 0) chk("spurious_rsp", 1, 0);
                else if (sbq[0].lat >= 0)
                    chk("latency", cyc - acc_cyc, sbq[0].lat);
                h_id = rsp_id; h_data = rsp_data;
                h_sp = rsp_special; h_err = rsp_err;
            end else if (rsp_valid) begin
                chk("hold_id", rsp_id, h_id);
                chk("hold_data", rsp_data, h_data);
                chk("hold_sp", rsp_special, h_sp);
                chk("hold_err", rsp_err, h_err);
            end
            if (rsp_valid && rsp_ready && sbq.size() > 0) begin
                exp_t e;
                e = sbq.pop_front();
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_special", rsp_special, e.sp);
                chk("rsp_err", rsp_err, e.err);
            end
            prev_valid = rsp_valid;
        end
    end

    // Datapath model: answers dp_lat cycles after dp_start, or stays silent.
    initial begin
        logic [1:0]  so;
        logic [31:0] sa, sb;
        int stray_seen;
        stray_seen = 0;
        dp_done = 1'b0;
        dp_res = '0;
        forever begin
            @(negedge clk);
            if (dp_start && !rst && dp_en) begin
                so = dp_op; sa = dp_a; sb = dp_b;
                repeat (dp_lat) @(posedge clk);
                #1;
                chk("dp_a_hold", dp_a, sa);
                chk("dp_b_hold", dp_b, sb);
                dp_res = dpf(so, sa, sb);
                dp_done = 1'b1;
                @(posedge clk);
                #1 dp_done = 1'b0;
            end else if (stray_seen != stray_cnt) begin
                stray_seen = stray_cnt;
                @(posedge clk);
                #1 dp_res = 32'hDEAD_BEEF;
                dp_done = 1'b1;
                @(posedge clk);
                #1 dp_done = 1'b0;
            end
        end
    end

    task automatic send(input int r, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b);
        int n, i;
        @(posedge clk);
        #1;
        if (r == 0) begin
            req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
        n = accepts;
        i = 0;
        while (accepts == n && i < 200) begin
            @(posedge clk);
            i++;
        end
        #1;
        if (accepts == n) chk("accept_timeout", 0, 1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (sbq.size() > 0 && i < 300) begin
            @(posedge clk);
            i++;
        end
        if (sbq.size() > 0) chk("drain_timeout", sbq.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [1:0]  t_op[9]  = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b11,
                              2'b01, 2'b00, 2'b01, 2'b01};
    logic [31:0] t_a[9]   = '{32'h8000_0000, 32'hFF80_0000, 32'hFF80_0000,
                              32'h7F80_0001, 32'h3F80_0000, 32'h7F80_0000,
                              32'h8000_0000, 32'h0000_0001, 32'hFF80_0000};
    logic [31:0] t_b[9]   = '{32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000,
                              32'h3F80_0000, 32'h3F80_0000, 32'h8000_0000,
                              32'h3F80_0000, 32'h7F80_0000, 32'h4000_0000};
    logic [31:0] t_d[9]   = '{32'h0000_0000, 32'h7F80_0000, 32'hFF80_0000,
                              32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000,
                              32'h8000_0000, 32'h7FC0_0000, 32'h7F80_0000};
    logic        t_err[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                              1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int s, i;
        rst = 1'b1;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00;
        req0_a = 32'h3F80_0000; req0_b = 32'h3F80_0000;
        req1_valid = 1'b0; req1_op = 2'b00; req1_a = '0; req1_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_dp_start", dp_start, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_special", rsp_special, 0);
        chk("rst_rsp_err", rsp_err, 0);
        req0_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        s = dp_starts;
        push(0, 32'hC0C0_0000, 0, 0, 5);
        send(0, 2'b00, 32'h4000_0000, 32'hC040_0000);
        drain();
        chk("mul_dp_starts", dp_starts - s, 1);

        s = dp_starts;
        push(1, 32'h7FC0_0000, 1, 0, 1);
        send(1, 2'b00, 32'h0000_0000, 32'h7F80_0000);
        for (i = 0; i < 9; i++) begin
            push(i[0], t_d[i], 1, t_err[i], 1);
            send(i % 2, t_op[i], t_a[i], t_b[i]);
        end
        drain();
        chk("special_dp_starts", dp_starts - s, 0);

        dp_lat = 1;
        push(0, dpf(2'b00, 32'h3FC0_0000, 32'h4020_0000), 0, 0, 3);
        send(0, 2'b00, 32'h3FC0_0000, 32'h4020_0000);
        drain();
        dp_lat = 3;
        push(1, dpf(2'b01, 32'h3F80_0000, 32'h4040_0000), 0, 0, 5);
        send(1, 2'b01, 32'h3F80_0000, 32'h4040_0000);
        drain();

        for (i = 0; i < 4; i++)
            push(i[0], i[0] ? dpf(2'b00, 32'h4040_0000, 32'h4080_0000)
                            : dpf(2'b00, 32'h3F80_0000, 32'h4000_0000),
                 0, 0, 5);
        @(posedge clk);
        #1;
        req0_op = 2'b00; req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000;
        req1_op = 2'b00; req1_a = 32'h4040_0000; req1_b = 32'h4080_0000;
        req0_valid = 1'b1; req1_valid = 1'b1;
        s = accepts;
        i = 0;
        while (accepts < s + 4 && i < 400) begin
            @(posedge clk);
            i++;
        end
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rr_accepts", accepts - s, 4);
        drain();

        dp_en = 1'b0;
        push(0, 32'h7FC0_0000, 0, 1, TO + 2);
        send(0, 2'b00, 32'h3F80_0000, 32'h3F80_0000);
        drain();
        stray_cnt++;
        repeat (6) @(posedge clk);
        #1;
        chk("stray_rsp_valid", rsp_valid, 0);
        dp_en = 1'b1;
        push(1, dpf(2'b00, 32'h4080_0000, 32'h3F00_0000), 0, 0, 5);
        send(1, 2'b00, 32'h4080_0000, 32'h3F00_0000);
        drain();

        rsp_ready = 1'b0;
        push(0, 32'h7FC0_0000, 1, 1, 1);
        send(0, 2'b11, 32'h0000_0000, 32'h0000_0000);
        repeat (10) @(posedge clk);
        #1;
        chk("stall_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        drain();

        dp_en = 1'b0;
        send(1, 2'b00, 32'h3F80_0000, 32'h3F80_0000);
        repeat (3) @(posedge clk);
        req0_op = 2'b00; req0_a = 32'h3F80_0000; req0_b = 32'h3F80_0000;
        req0_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_ready", req0_ready, 0);
        chk("mid_rst_dp_start", dp_start, 0);
        chk("mid_rst_data", rsp_data, 0);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        s = dp_starts;
        repeat (TO + 10) @(posedge clk);
        #1;
        chk("post_rst_valid", rsp_valid, 0);
        chk("post_rst_dp_starts", dp_starts - s, 0);
        chk("post_rst_queue", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
